// File: rtl/median_frame_sched_if.sv
// Pixel stream bundle: valid/ready handshake carrying one 8-bit pixel with frame/line markers.
interface median_frame_sched_if;
    logic       valid;
    logic       ready;
    logic [7:0] pixel;
    logic       sof;
    logic       eol;

    modport master (output valid, output pixel, output sof, output eol, input ready);
    modport slave  (input valid, input pixel, input sof, input eol, output ready);
endinterface

// File: rtl/median_frame_sched.sv
// Frame sequencer in front of the 3x3 median stage: regenerates exact WxH geometry, pads short frames.
// Zero-latency combinational forward path; source stalls on the active path's ready, and during PAD/DRAIN.
module median_frame_sched #(
    parameter int W = 160,
    parameter int H = 120
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_enable_i,
    input  logic                          cfg_bypass_i,
    median_frame_sched_if.slave           s_if,
    median_frame_sched_if.master          f_if,
    median_frame_sched_if.slave           r_if,
    median_frame_sched_if.master          m_if,
    output logic                          busy_o,
    output logic                          frame_done_o,
    output logic                          err_sync_o,
    output logic                          err_line_o,
    output logic [15:0]                   frame_cnt_o
);

    localparam int XW   = (W > 1) ? $clog2(W) : 1;
    localparam int YW   = (H > 1) ? $clog2(H) : 1;
    localparam int NPIX = W * H;
    localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(H - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NPIX - 1);

    typedef enum logic [2:0] {IDLE, WAIT_SOF, RUN, PAD, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            bypass_q, bypass_d;
    logic            pend_q, pend_d;
    logic            done_q, done_d;
    logic            esync_q, esync_d;
    logic            eline_q, eline_d;

    logic            s_ready;
    logic            f_valid, f_sof, f_eol;
    logic [7:0]      f_pixel;
    logic            m_valid, m_sof, m_eol;
    logic [7:0]      m_pixel;
    logic            r_ready;

    logic            pos_first, pos_eol, pos_last;
    logic            early, adv, out_beat, frame_act;
    logic            path_vld, path_rdy;
    logic [7:0]      path_pix;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        out_cnt_d   = out_cnt_q;
        frame_cnt_d = frame_cnt_q;
        bypass_d    = bypass_q;
        pend_d      = pend_q;
        done_d      = 1'b0;
        esync_d     = 1'b0;
        eline_d     = 1'b0;

        s_ready  = 1'b0;
        f_valid  = 1'b0;
        f_pixel  = 8'd0;
        f_sof    = 1'b0;
        f_eol    = 1'b0;
        m_valid  = 1'b0;
        m_pixel  = 8'd0;
        m_sof    = 1'b0;
        m_eol    = 1'b0;
        r_ready  = 1'b0;

        pos_first = (x_q == '0) && (y_q == '0);
        pos_eol   = (x_q == X_LAST);
        pos_last  = pos_eol && (y_q == Y_LAST);
        early     = 1'b0;
        adv       = 1'b0;
        path_vld  = 1'b0;
        path_pix  = 8'd0;
        path_rdy  = bypass_q ? m_if.ready : f_if.ready;
        frame_act = (state_q == RUN) || (state_q == PAD) || (state_q == DRAIN);

        case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (cfg_enable_i) begin
                    state_d = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                // The SOF beat is left on the bus so RUN consumes it as pixel (0,0).
                s_ready = !(s_if.valid && s_if.sof);
                if (s_if.valid && s_if.sof) begin
                    bypass_d = cfg_bypass_i;
                    x_d      = '0;
                    y_d      = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                early    = s_if.valid && s_if.sof && !pos_first;
                path_vld = s_if.valid && !early;
                path_pix = s_if.pixel;
                s_ready  = path_rdy && !early;
                if (s_if.valid && s_ready) begin
                    adv     = 1'b1;
                    eline_d = (s_if.eol != pos_eol);
                end else if (early) begin
                    esync_d = 1'b1;
                    pend_d  = 1'b1;
                    state_d = PAD;
                end
            end
            PAD: begin
                path_vld = 1'b1;
                path_pix = 8'd0;
                adv      = path_rdy;
            end
            DRAIN: begin
                s_ready = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q == RUN) || (state_q == PAD)) begin
            if (bypass_q) begin
                m_valid = path_vld;
                m_pixel = path_pix;
                m_sof   = pos_first;
                m_eol   = pos_eol;
            end else begin
                f_valid = path_vld;
                f_pixel = path_pix;
                f_sof   = pos_first;
                f_eol   = pos_eol;
            end
        end

        if (frame_act && !bypass_q) begin
            m_valid = r_if.valid;
            m_pixel = r_if.pixel;
            m_sof   = r_if.sof;
            m_eol   = r_if.eol;
            r_ready = m_if.ready;
        end

        if (adv) begin
            if (pos_eol) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
            if (pos_last) begin
                state_d = DRAIN;
            end
        end

        // Frame completion wins over any RUN/PAD transition in the same cycle (bypass last beat).
        out_beat = m_valid && m_if.ready;
        if (out_beat) begin
            if (out_cnt_q == CNT_LAST) begin
                out_cnt_d   = '0;
                frame_cnt_d = frame_cnt_q + 16'd1;
                done_d      = 1'b1;
                if (pend_q) begin
                    pend_d   = 1'b0;
                    bypass_d = cfg_bypass_i;
                    x_d      = '0;
                    y_d      = '0;
                    state_d  = RUN;
                end else begin
                    state_d = cfg_enable_i ? WAIT_SOF : IDLE;
                end
            end else begin
                out_cnt_d = out_cnt_q + CW'(1);
            end
        end

        if (reset) begin
            s_ready = 1'b0;
            f_valid = 1'b0;
            r_ready = 1'b0;
            m_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            out_cnt_q   <= '0;
            frame_cnt_q <= 16'd0;
            bypass_q    <= 1'b0;
            pend_q      <= 1'b0;
            done_q      <= 1'b0;
            esync_q     <= 1'b0;
            eline_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            out_cnt_q   <= out_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            bypass_q    <= bypass_d;
            pend_q      <= pend_d;
            done_q      <= done_d;
            esync_q     <= esync_d;
            eline_q     <= eline_d;
        end
    end

    assign s_if.ready   = s_ready;
    assign f_if.valid   = f_valid;
    assign f_if.pixel   = f_pixel;
    assign f_if.sof     = f_sof;
    assign f_if.eol     = f_eol;
    assign r_if.ready   = r_ready;
    assign m_if.valid   = m_valid;
    assign m_if.pixel   = m_pixel;
    assign m_if.sof     = m_sof;
    assign m_if.eol     = m_eol;

    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = done_q;
    assign err_sync_o   = esync_q;
    assign err_line_o   = eline_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_median_frame_sched.sv
// Directed bench for median_frame_sched at 8x4 with a 2-cycle pixel+1 filter model.
module tb_median_frame_sched;
    localparam int W = 8;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_enable;
    logic        cfg_bypass;
    logic        busy, frame_done, err_sync, err_line;
    logic [15:0] frame_cnt;
    logic        mr_tog = 1'b0;
    logic [7:0]  tcyc = 8'd0;

    median_frame_sched_if s_if();
    median_frame_sched_if f_if();
    median_frame_sched_if r_if();
    median_frame_sched_if m_if();

    median_frame_sched #(.W(W), .H(H)) dut (
        .clk(clk), .reset(reset),
        .cfg_enable_i(cfg_enable), .cfg_bypass_i(cfg_bypass),
        .s_if(s_if), .f_if(f_if), .r_if(r_if), .m_if(m_if),
        .busy_o(busy), .frame_done_o(frame_done), .err_sync_o(err_sync),
        .err_line_o(err_line), .frame_cnt_o(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tcyc <= tcyc + 8'd1;
    assign m_if.ready = !mr_tog || tcyc[0];

    // Filter model: each beat reappears on r two cycles later with pixel+1.
    logic [9:0] mdl_q[$];
    int         mdl_t[$];
    int         mcyc = 0;
    always @(posedge clk) begin
        if (reset) begin
            mdl_q.delete();
            mdl_t.delete();
            r_if.valid <= 1'b0;
            r_if.pixel <= 8'd0;
            r_if.sof   <= 1'b0;
            r_if.eol   <= 1'b0;
            f_if.ready <= 1'b1;
        end else begin
            mcyc = mcyc + 1;
            if (r_if.valid && r_if.ready) begin
                void'(mdl_q.pop_front());
                void'(mdl_t.pop_front());
            end
            if (f_if.valid && f_if.ready) begin
                mdl_q.push_back({f_if.sof, f_if.eol, 8'(f_if.pixel + 8'd1)});
                mdl_t.push_back(mcyc);
            end
            if (mdl_q.size() > 0 && mdl_t[0] <= mcyc - 1) begin
                r_if.valid <= 1'b1;
                {r_if.sof, r_if.eol, r_if.pixel} <= mdl_q[0];
            end else begin
                r_if.valid <= 1'b0;
            end
            f_if.ready <= (mdl_q.size() < 4);
        end
    end

    logic [9:0] fq[$];
    logic [9:0] mq[$];
    int         done_at[$];
    int         done_cnt = 0, es_cnt = 0, el_cnt = 0, rr_cnt = 0;
    always @(posedge clk) begin
        if (!reset) begin
            if (frame_done) begin
                done_cnt = done_cnt + 1;
                done_at.push_back(mq.size());
            end
            if (err_sync) es_cnt = es_cnt + 1;
            if (err_line) el_cnt = el_cnt + 1;
            if (r_if.ready) rr_cnt = rr_cnt + 1;
            if (m_if.valid && m_if.ready) mq.push_back({m_if.sof, m_if.eol, m_if.pixel});
            if (f_if.valid && f_if.ready) fq.push_back({f_if.sof, f_if.eol, f_if.pixel});
        end
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] px(input int fr, input int b);
        return 8'(fr * 37 + b * 3 + 1);
    endfunction

    function automatic logic [9:0] ew(input int fr, input int b, input int add);
        return {1'(b == 0), 1'(b % 8 == 7), 8'(px(fr, b) + add)};
    endfunction

    task automatic drive(input logic [7:0] pix, input logic sof, input logic eol);
        int k;
        k = 0;
        s_if.valid = 1'b1;
        s_if.pixel = pix;
        s_if.sof   = sof;
        s_if.eol   = eol;
        @(negedge clk);
        while (!s_if.ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk("drive_timeout", 32'(s_if.ready), 32'd1);
        @(posedge clk);
        #1;
        s_if.valid = 1'b0;
        s_if.sof   = 1'b0;
        s_if.eol   = 1'b0;
    endtask

    task automatic send(input int fr, input int nb, input int bad_eol);
        for (int b = 0; b < nb; b++)
            drive(px(fr, b), 1'(b == 0), 1'((b % 8 == 7) || (b == bad_eol)));
    endtask

    task automatic wait_done(input int n, input string tag);
        int k;
        k = 0;
        while (done_cnt < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(done_cnt), 32'(n));
    endtask

    int fb = 0;
    int mb = 0;
    int rr_base;

    initial begin
        reset      = 1'b1;
        cfg_enable = 1'b0;
        cfg_bypass = 1'b0;
        s_if.valid = 1'b0;
        s_if.pixel = 8'd0;
        s_if.sof   = 1'b0;
        s_if.eol   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 32'(s_if.ready), 32'd0);
        chk("rst_f_valid", 32'(f_if.valid), 32'd0);
        chk("rst_m_valid", 32'(m_if.valid), 32'd0);
        chk("rst_r_ready", 32'(r_if.ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_s_ready", 32'(s_if.ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        // Non-SOF beats while waiting for a frame are swallowed.
        cfg_enable = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            s_if.valid = 1'b1;
            s_if.pixel = 8'(8'hA0 + k);
            @(negedge clk);
            chk("ws_busy", 32'(busy), 32'd1);
            chk("ws_s_ready", 32'(s_if.ready), 32'd1);
            chk("ws_f_valid", 32'(f_if.valid), 32'd0);
            chk("ws_m_valid", 32'(m_if.valid), 32'd0);
            @(posedge clk); #1;
        end
        s_if.valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("ws_no_f", 32'(fq.size()), 32'd0);
        chk("ws_no_m", 32'(mq.size()), 32'd0);

        // Two median frames back to back.
        send(1, 32, -1);
        send(2, 32, -1);
        wait_done(2, "m_done2");
        chk("m_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("m_done_at0", 32'(done_at[0]), 32'd32);
        chk("m_done_at1", 32'(done_at[1]), 32'd64);
        chk("m_fq_size", 32'(fq.size()), 32'd64);
        chk("m_mq_size", 32'(mq.size()), 32'd64);
        for (int i = 0; i < 64; i++) begin
            chk("m_f_beat", 32'(fq[i]), 32'(ew(1 + i / 32, i % 32, 0)));
            chk("m_m_beat", 32'(mq[i]), 32'(ew(1 + i / 32, i % 32, 1)));
        end
        chk("m_no_errs", 32'(es_cnt + el_cnt), 32'd0);
        fb = 64; mb = 64;

        // Early SOF at beat 20 forces padding, then the held SOF starts frame 4.
        send(3, 20, -1);
        send(4, 32, -1);
        wait_done(4, "es_done4");
        chk("es_pulse", 32'(es_cnt), 32'd1);
        chk("es_frame_cnt", 32'(frame_cnt), 32'd4);
        chk("es_fq_size", 32'(fq.size() - fb), 32'd64);
        chk("es_mq_size", 32'(mq.size() - mb), 32'd64);
        for (int b = 0; b < 20; b++) chk("es_src", 32'(fq[fb + b]), 32'(ew(3, b, 0)));
        for (int b = 20; b < 32; b++) chk("es_pad", 32'(fq[fb + b]), {22'd0, 1'b0, 1'(b % 8 == 7), 8'd0});
        for (int b = 0; b < 32; b++) chk("es_next", 32'(fq[fb + 32 + b]), 32'(ew(4, b, 0)));
        fb += 64; mb += 64;

        // Bypass latched at SOF; dropping cfg_bypass mid-frame has no effect until next frame.
        cfg_bypass = 1'b1;
        rr_base = rr_cnt;
        for (int b = 0; b < 32; b++) begin
            if (b == 10) cfg_bypass = 1'b0;
            drive(px(5, b), 1'(b == 0), 1'(b % 8 == 7));
        end
        wait_done(5, "bp_done5");
        chk("bp_r_ready", 32'(rr_cnt - rr_base), 32'd0);
        chk("bp_fq_size", 32'(fq.size() - fb), 32'd0);
        chk("bp_mq_size", 32'(mq.size() - mb), 32'd32);
        for (int b = 0; b < 32; b++) chk("bp_m", 32'(mq[mb + b]), 32'(ew(5, b, 0)));
        mb += 32;
        send(6, 32, -1);
        wait_done(6, "bp_done6");
        chk("bp2_fq_size", 32'(fq.size() - fb), 32'd32);
        for (int b = 0; b < 32; b++) chk("bp2_m", 32'(mq[mb + b]), 32'(ew(6, b, 1)));
        fb += 32; mb += 32;

        // Sink backpressure on alternate cycles.
        mr_tog = 1'b1;
        send(7, 32, -1);
        wait_done(7, "bk_done7");
        repeat (10) @(negedge clk);
        chk("bk_mq_size", 32'(mq.size() - mb), 32'd32);
        for (int b = 0; b < 32; b++) chk("bk_m", 32'(mq[mb + b]), 32'(ew(7, b, 1)));
        mr_tog = 1'b0;
        fb += 32; mb += 32;

        // Misplaced eol at beat 5, then reset mid-frame.
        send(8, 15, 5);
        chk("el_pulse", 32'(el_cnt), 32'd1);
        chk("el_f_eol", 32'(fq[fb + 5]), {22'd0, 1'b0, 1'b0, px(8, 5)});
        reset = 1'b1;
        @(negedge clk);
        chk("mr_s_ready", 32'(s_if.ready), 32'd0);
        chk("mr_f_valid", 32'(f_if.valid), 32'd0);
        chk("mr_r_ready", 32'(r_if.ready), 32'd0);
        chk("mr_m_valid", 32'(m_if.valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("mr_f_valid2", 32'(f_if.valid), 32'd0);
        chk("mr_m_valid2", 32'(m_if.valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
